// File: rtl/pipe_reg_chain.sv
// Elastic register chain: DEPTH valid/data stages with combinational ready
// propagation, bubble collapse, synchronous flush and an occupancy counter.
module pipe_reg_chain #(
  parameter int              WIDTH     = 64,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_rdy;
  logic             in_acc;
  logic             out_acc;

  // Ready chain walked from the output back: a stage is blocked only if it
  // is valid and everything downstream of it is blocked as well.
  always_comb begin : ready_chain
    logic blocked;
    blocked = !out_ready;
    adv     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]  = v[i] && !blocked;
      blocked = v[i] && blocked;
    end
    in_rdy = !blocked;
  end

  // Stage 0 loads from the input port, every other stage from its upstream neighbour.
  always_comb begin
    load    = '0;
    load[0] = in_valid && in_rdy;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
    end
  end

  assign in_acc    = load[0];
  assign out_acc   = adv[DEPTH-1];
  assign in_ready  = in_rdy;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Valid bits and occupancy count; flush empties the chain but still lets
  // the current output transfer complete downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v     <= '0;
      count <= '0;
    end else if (flush) begin
      v     <= '0;
      count <= '0;
    end else begin
      v <= load | (v & ~adv);
      case ({in_acc, out_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Data registers move only when their stage loads, so idle stages never toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (!flush) begin
      if (load[0]) begin
        d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (load[i]) begin
          d[i] <= d[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain: directed vector table, hand-written
// corner sequences and randomized runs against a queue-based reference model.
module tb_pipe_reg_chain;

  localparam logic [63:0] RV_A = 64'h0123_4567_89AB_CDEF;

  logic        clk;
  logic        rst;
  logic        iv;
  logic [63:0] i_dat;
  logic        ordy;
  logic        fl;

  logic        a_ir, a_ov;
  logic [63:0] a_od;
  logic [2:0]  a_cnt;
  logic        b_ir, b_ov;
  logic [7:0]  b_od;
  logic [0:0]  b_cnt;
  logic        c_ir, c_ov;
  logic [0:0]  c_od;
  logic [1:0]  c_cnt;

  int          sel;
  logic        m_ir, m_ov;
  logic [63:0] m_od;
  logic [63:0] m_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    int          rc;
  } item_t;
  item_t       mq[$];
  int          cyc;
  int          depth_m;
  logic [63:0] mask;

  typedef struct {
    logic        iv;
    logic [63:0] id;
    logic        ordy;
    logic        e_ov;
    logic [63:0] e_od;
    int          e_cnt;
    logic        e_ir;
  } vec_t;
  vec_t tbl[15];

  pipe_reg_chain #(.WIDTH(64), .DEPTH(4), .RESET_VAL(RV_A)) u_a (
    .clk(clk), .reset(rst), .in_valid(iv), .in_data(i_dat), .in_ready(a_ir),
    .out_valid(a_ov), .out_data(a_od), .out_ready(ordy), .flush(fl), .count(a_cnt));

  pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u_b (
    .clk(clk), .reset(rst), .in_valid(iv), .in_data(i_dat[7:0]), .in_ready(b_ir),
    .out_valid(b_ov), .out_data(b_od), .out_ready(ordy), .flush(fl), .count(b_cnt));

  pipe_reg_chain #(.WIDTH(1), .DEPTH(3), .RESET_VAL(1'b1)) u_c (
    .clk(clk), .reset(rst), .in_valid(iv), .in_data(i_dat[0]), .in_ready(c_ir),
    .out_valid(c_ov), .out_data(c_od), .out_ready(ordy), .flush(fl), .count(c_cnt));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin
        m_ir = b_ir; m_ov = b_ov; m_od = {56'd0, b_od}; m_cnt = {63'd0, b_cnt};
      end
      2: begin
        m_ir = c_ir; m_ov = c_ov; m_od = {63'd0, c_od}; m_cnt = {62'd0, c_cnt};
      end
      default: begin
        m_ir = a_ir; m_ov = a_ov; m_od = a_od; m_cnt = {61'd0, a_cnt};
      end
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iv = 1'b0; fl = 1'b0; ordy = 1'b0; i_dat = 64'd0;
    #2;
    rst = 1'b0;
    mq.delete();
    cyc = 0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: items carry the earliest cycle they may appear at the output.
  task automatic mstep();
    int   n;
    logic eir, eov, oacc, iacc;
    #1;
    n   = mq.size();
    eir = (n < depth_m) || ordy;
    eov = (n > 0) && (mq[0].rc <= cyc);
    chk("rnd_count", m_cnt, 64'(n));
    chk("rnd_in_ready", 64'(m_ir), 64'(eir));
    chk("rnd_out_valid", 64'(m_ov), 64'(eov));
    if (eov) chk("rnd_out_data", m_od, mq[0].data);
    oacc = eov && ordy;
    iacc = iv && eir;
    if (oacc) begin
      void'(mq.pop_front());
      if (mq.size() > 0 && mq[0].rc < cyc + 1) mq[0].rc = cyc + 1;
    end
    if (fl) mq.delete();
    else if (iacc) mq.push_back('{i_dat & mask, cyc + depth_m});
    edge_step();
    cyc++;
  endtask

  function automatic vec_t mk(input logic v_iv, input logic [63:0] v_id, input logic v_or,
                              input logic v_ov, input logic [63:0] v_od, input int v_cnt,
                              input logic v_ir);
    vec_t r;
    r.iv = v_iv; r.id = v_id; r.ordy = v_or; r.e_ov = v_ov;
    r.e_od = v_od; r.e_cnt = v_cnt; r.e_ir = v_ir;
    return r;
  endfunction

  initial begin
    // Backpressure / bubble collapse: A, two idle cycles, B, C, D; E refused while full.
    tbl[0]  = mk(1'b1, 64'hA, 1'b0, 1'b0, 64'h0, 0, 1'b1);
    tbl[1]  = mk(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1, 1'b1);
    tbl[2]  = mk(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1, 1'b1);
    tbl[3]  = mk(1'b1, 64'hB, 1'b0, 1'b0, 64'h0, 1, 1'b1);
    tbl[4]  = mk(1'b0, 64'h0, 1'b0, 1'b1, 64'hA, 2, 1'b1);
    tbl[5]  = mk(1'b0, 64'h0, 1'b0, 1'b1, 64'hA, 2, 1'b1);
    tbl[6]  = mk(1'b1, 64'hC, 1'b0, 1'b1, 64'hA, 2, 1'b1);
    tbl[7]  = mk(1'b1, 64'hD, 1'b0, 1'b1, 64'hA, 3, 1'b1);
    tbl[8]  = mk(1'b1, 64'hE, 1'b0, 1'b1, 64'hA, 4, 1'b0);
    tbl[9]  = mk(1'b1, 64'hE, 1'b0, 1'b1, 64'hA, 4, 1'b0);
    tbl[10] = mk(1'b0, 64'h0, 1'b1, 1'b1, 64'hA, 4, 1'b1);
    tbl[11] = mk(1'b0, 64'h0, 1'b1, 1'b1, 64'hB, 3, 1'b1);
    tbl[12] = mk(1'b0, 64'h0, 1'b1, 1'b1, 64'hC, 2, 1'b1);
    tbl[13] = mk(1'b0, 64'h0, 1'b1, 1'b1, 64'hD, 1, 1'b1);
    tbl[14] = mk(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 0, 1'b1);

    clk = 1'b0; rst = 1'b1; iv = 1'b0; fl = 1'b0; ordy = 1'b0; i_dat = 64'd0;
    sel = 0; cyc = 0; depth_m = 4; mask = '1;
    #2;
    chk("rst_a_out_valid", 64'(a_ov), 64'd0);
    chk("rst_a_out_data", a_od, RV_A);
    chk("rst_a_count", 64'(a_cnt), 64'd0);
    chk("rst_a_in_ready", 64'(a_ir), 64'd1);
    chk("rst_b_out_data", 64'(b_od), 64'h5A);
    chk("rst_c_out_data", 64'(c_od), 64'd1);
    chk("rst_c_in_ready", 64'(c_ir), 64'd1);

    // Directed vector table on the DEPTH=4 build.
    do_reset();
    for (int k = 0; k < 15; k++) begin
      iv = tbl[k].iv; i_dat = tbl[k].id; ordy = tbl[k].ordy;
      #1;
      chk("tbl_out_valid", 64'(m_ov), 64'(tbl[k].e_ov));
      if (tbl[k].e_ov) chk("tbl_out_data", m_od, tbl[k].e_od);
      chk("tbl_count", m_cnt, 64'(tbl[k].e_cnt));
      chk("tbl_in_ready", 64'(m_ir), 64'(tbl[k].e_ir));
      edge_step();
    end

    // Streaming 1,2,3...: first output four cycles after first accept, then
    // full with simultaneous accept and drain every cycle.
    do_reset();
    ordy = 1'b1;
    for (int c = 0; c < 12; c++) begin
      iv = 1'b1; i_dat = 64'(c + 1);
      #1;
      chk("stream_count", m_cnt, 64'((c < 4) ? c : 4));
      chk("stream_out_valid", 64'(m_ov), 64'(c >= 4));
      if (c >= 4) chk("stream_out_data", m_od, 64'(c - 3));
      chk("stream_in_ready", 64'(m_ir), 64'd1);
      edge_step();
    end

    // Flush with 3 items held while 0xAA is offered.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; i_dat = 64'h11 * 64'(k + 1);
      edge_step();
    end
    iv = 1'b1; i_dat = 64'hAA; fl = 1'b1;
    #1;
    chk("flush_pre_count", m_cnt, 64'd3);
    edge_step();
    fl = 1'b0; iv = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("flush_out_valid", 64'(m_ov), 64'd0);
      chk("flush_count", m_cnt, 64'd0);
      if (k == 0) chk("flush_data_untouched", m_od, RV_A);
      edge_step();
    end

    // Asynchronous reset between edges with 3 items in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; i_dat = 64'h70 + 64'(k);
      edge_step();
    end
    iv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(m_ov), 64'd0);
    chk("arst_out_data", m_od, RV_A);
    chk("arst_count", m_cnt, 64'd0);
    chk("arst_in_ready", 64'(m_ir), 64'd1);
    iv = 1'b1; i_dat = 64'h55; ordy = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      edge_step();
      iv = 1'b0;
      #1;
      chk("arst_latency_valid", 64'(m_ov), 64'(k == 4));
      if (k == 4) begin
        chk("arst_item_data", m_od, 64'h55);
        chk("arst_item_count", m_cnt, 64'd1);
      end
    end

    // Randomized runs on all three builds against the queue model.
    for (int p = 0; p < 3; p++) begin
      sel = p;
      depth_m = (p == 0) ? 4 : ((p == 1) ? 1 : 3);
      mask = (p == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : ((p == 1) ? 64'hFF : 64'h1);
      do_reset();
      for (int n = 0; n < 500; n++) begin
        iv    = ($urandom_range(0, 3) != 0);
        i_dat = {$urandom, $urandom};
        ordy  = (n < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        fl    = ($urandom_range(0, 39) == 0);
        mstep();
      end
      fl = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
